reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits of every entry.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1, when 1 a same-cycle write is forwarded to reads of the same address.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wr_en  input  1  write request this cycle.
REQ-008 write_reg  input  ADDR_W  write address.
REQ-009 write_data  input  WIDTH  write data.
REQ-010 rd_en_a / rd_en_b  input  1 each  read request, port A / port B.
REQ-011 read_reg_a / read_reg_b  input  ADDR_W each  read address, port A / port B.
REQ-012 read_data_a / read_data_b  output  WIDTH each  registered read data, port A / port B.
REQ-013 clr_req  input  1  request to zero all entries.
REQ-014 busy  output  1  high while the clear sequence runs.

Function
REQ-015 Storage: DEPTH x WIDTH flops, no reset-value dependence on read-port state.
REQ-016 Write: wr_en=1 at edge N with busy=0 updates entry write_reg with write_data at edge N.
REQ-017 Writes to address 0 are discarded when ZERO_REG=1; reads of address 0 then always return 0.
REQ-018 Read: rd_en_x=1 at edge N loads read_data_x at edge N; latency 1 cycle; rd_en_x=0 holds read_data_x unchanged.
REQ-019 Ports A and B are independent; identical addresses on both return identical data.
REQ-020 Read/write collision, same edge, same address (not zero-reg): BYPASS=1 -> read_data returns write_data; BYPASS=0 -> returns prior stored value.
REQ-021 FSM states IDLE, CLEAR; reset state IDLE.
REQ-022 IDLE -> CLEAR when clr_req=1 at an edge; clear index counter loaded with 0.
REQ-023 CLEAR: one entry zeroed per cycle, index 0..DEPTH-1 ascending; CLEAR -> IDLE on the edge zeroing entry DEPTH-1; sequence lasts exactly DEPTH cycles.
REQ-024 busy is registered: 1 from the edge entering CLEAR until the edge returning to IDLE.
REQ-025 clr_req while busy=1 is ignored (no restart, no queueing).
REQ-026 wr_en while busy=1 is dropped silently.
REQ-027 Reads while busy=1 are serviced and return current stored contents (already-cleared entries read 0); no bypass of clear writes.
REQ-028 clr_req and wr_en at the same edge in IDLE: the write is performed, CLEAR starts, and the written entry is subsequently zeroed.
REQ-029 Clear index counter is ADDR_W bits and wraps to 0 on exit; no out-of-range access.

Reset
REQ-030 rst_n=0 immediately forces all entries to 0, read_data_a=0, read_data_b=0, busy=0, FSM=IDLE, clear index=0, independent of clk.
REQ-031 rst_n low during CLEAR aborts the sequence; on release block is IDLE with all entries 0.
REQ-032 First write/read/clear accepted at the first posedge clk after rst_n deasserts.

Verification
REQ-033 Reset, write 0xDEADBEEF to reg 5, next cycle read A=5 -> read_data_a=0xDEADBEEF one cycle after rd_en_a.
REQ-034 Write 0x12345678 to reg 0, read A=0 and B=0 -> both 0 (ZERO_REG=1); with ZERO_REG=0 both 0x12345678.
REQ-035 Reg 3 holds 0x11; same edge write 0x22 to reg 3 and read A=3 -> 0x22 (BYPASS=1), 0x11 (BYPASS=0); next read 0x22 both cases.
REQ-036 Fill all 16 entries, pulse clr_req -> busy high 16 cycles; write to reg 7 during busy dropped; reading reg 15 at clear cycle 3 returns old value, after busy falls all regs read 0.
REQ-037 clr_req and write 0xAA to reg 2 same edge -> after clear reg 2 reads 0; second clr_req mid-clear -> busy still exactly 16 cycles.
REQ-038 Assert rst_n=0 asynchronously at clear cycle 8 -> busy, read_data_a/b drop to 0 without clock edge; after release IDLE, all reads 0.

Source files
------------

// File: rtl/reg_file.sv
// Two-read / one-write register file with an optional hardwired zero entry,
// optional write-to-read forwarding, and a one-entry-per-cycle clear sequencer.
module reg_file #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              rd_en_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] read_reg_a,
  input  logic [ADDR_W-1:0] read_reg_b,
  output logic [WIDTH-1:0]  read_data_a,
  output logic [WIDTH-1:0]  read_data_b,
  input  logic              clr_req,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NPORT = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                               state;
  logic [ADDR_W-1:0]                    clr_idx;
  logic [DEPTH-1:0][WIDTH-1:0]          mem;
  logic                                 wr_ok;
  logic [NPORT-1:0]                     rd_en;
  logic [NPORT-1:0][ADDR_W-1:0]         rd_addr;
  logic [NPORT-1:0][WIDTH-1:0]          rd_data;

  // Entry 0 is never written when hardwired, so its flops stay at reset zero
  // and a plain array read returns 0 without an extra read-side mux.
  assign wr_ok = wr_en && !busy && !(ZERO_REG != 0 && write_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_idx <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clr_req) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          clr_idx <= '0;
        end
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == ADDR_W'(DEPTH-1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A clear-start edge is still IDLE, so a coincident write lands first and
  // is wiped later when the sweep reaches its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem <= '0;
    else if (busy)
      mem[clr_idx] <= '0;
    else if (wr_ok)
      mem[write_reg] <= write_data;
  end

  assign rd_en   = {rd_en_b, rd_en_a};
  assign rd_addr = {read_reg_b, read_reg_a};

  // Forwarding keys off wr_ok, so dropped writes and clear zeroing never bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else
      for (int p = 0; p < NPORT; p++)
        if (rd_en[p])
          rd_data[p] <= (BYPASS != 0 && wr_ok && write_reg == rd_addr[p])
                        ? write_data : mem[rd_addr[p]];
  end

  assign read_data_a = rd_data[0];
  assign read_data_b = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: two instances (default params, and no zero-reg /
// no bypass) share stimulus; read expectations go through per-port queues.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  read_reg_a, read_reg_b;
  logic        clr_req;
  logic [31:0] read_data_a, read_data_b, read_data_a2, read_data_b2;
  logic        busy, busy2;

  int errors = 0;
  int checks = 0;
  int n;
  logic [31:0] qa[$], qb[$], qa2[$], qb2[$];

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .write_reg(write_reg),
    .write_data(write_data), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .clr_req(clr_req), .busy(busy)
  );

  reg_file #(.ZERO_REG(0), .BYPASS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .write_reg(write_reg),
    .write_data(write_data), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
    .read_data_a(read_data_a2), .read_data_b(read_data_b2),
    .clr_req(clr_req), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read issued at an edge is checked 1 time unit later.
  always begin
    logic sa, sb;
    @(posedge clk);
    sa = rd_en_a;
    sb = rd_en_b;
    #1;
    if (sa) begin
      if (qa.size() == 0 || qa2.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_a: no expectation queued at %0t", $time);
      end else begin
        chk("rd_a",  read_data_a,  qa.pop_front());
        chk("rd_a2", read_data_a2, qa2.pop_front());
      end
    end
    if (sb) begin
      if (qb.size() == 0 || qb2.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_b: no expectation queued at %0t", $time);
      end else begin
        chk("rd_b",  read_data_b,  qb.pop_front());
        chk("rd_b2", read_data_b2, qb2.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Inputs change 2 units after a posedge; the monitor samples at +1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wr_en = 0; rd_en_a = 0; rd_en_b = 0; clr_req = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1; write_reg = a; write_data = d;
  endtask

  task automatic rda(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e2);
    rd_en_a = 1; read_reg_a = a; qa.push_back(e1); qa2.push_back(e2);
  endtask

  task automatic rdb(input logic [3:0] a, input logic [31:0] e1, input logic [31:0] e2);
    rd_en_b = 1; read_reg_b = a; qb.push_back(e1); qb2.push_back(e2);
  endtask

  initial begin
    rst_n = 0; idle();
    write_reg = 0; write_data = 0; read_reg_a = 0; read_reg_b = 0;
    #1;
    chk("rst_rd_a", read_data_a, 0);
    chk("rst_rd_b", read_data_b, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    tick(); tick();
    rst_n = 1;

    // Write then read on the following cycle.
    wr(5, 32'hDEADBEEF); tick(); idle();
    rda(5, 32'hDEADBEEF, 32'hDEADBEEF); rdb(5, 32'hDEADBEEF, 32'hDEADBEEF);
    tick(); idle();

    // Zero register: discarded on dut, stored on dut2.
    wr(0, 32'h12345678); tick(); idle();
    rda(0, 0, 32'h12345678); rdb(0, 0, 32'h12345678); tick(); idle();

    // Same-edge collision: bypass on dut, stored value on dut2.
    wr(3, 32'h11); tick(); idle();
    wr(3, 32'h22); rda(3, 32'h22, 32'h11); tick(); idle();
    rda(3, 32'h22, 32'h22); rdb(3, 32'h22, 32'h22); tick(); idle();
    read_reg_a = 5; tick();
    chk("hold_a", read_data_a, 32'h22);

    // Fill all entries, then run a full clear.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 32'h100 + i); tick(); idle();
    end
    clr_req = 1; tick(); idle();
    chk("busy_enter", {31'd0, busy}, 1);
    chk("busy2_enter", {31'd0, busy2}, 1);
    n = 0;
    while (busy && n < 40) begin
      if (n == 3) begin rda(15, 32'h10F, 32'h10F); rdb(3, 32'h103, 32'h103); end
      if (n == 4) rdb(1, 0, 0);
      if (n == 10) wr(7, 32'h77);
      tick(); idle(); n++;
    end
    chk("clr_len", n, 16);
    chk("busy2_exit", {31'd0, busy2}, 0);
    for (int i = 0; i < 16; i++) begin
      rda(4'(i), 0, 0); rdb(4'(15 - i), 0, 0); tick(); idle();
    end

    // Coincident write + clear start, plus a clear request mid-sequence.
    wr(2, 32'hAA); clr_req = 1; tick(); idle();
    n = 0;
    while (busy && n < 40) begin
      if (n == 1) rda(2, 32'hAA, 32'hAA);
      if (n == 5) clr_req = 1;
      tick(); idle(); n++;
    end
    chk("clr2_len", n, 16);
    tick();
    chk("no_requeue", {31'd0, busy}, 0);
    rda(2, 0, 0); tick(); idle();

    // Asynchronous reset in the middle of a clear.
    wr(9, 32'h99); tick(); idle();
    wr(12, 32'hCC); tick(); idle();
    rda(9, 32'h99, 32'h99); rdb(12, 32'hCC, 32'hCC); tick(); idle();
    clr_req = 1; tick(); idle();
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_rd_a", read_data_a, 0);
    chk("arst_rd_b", read_data_b, 0);
    chk("arst_rd_a2", read_data_a2, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 16; i++) begin
      rda(4'(i), 0, 0); rdb(4'(15 - i), 0, 0); tick(); idle();
    end

    tick();
    chk("queues_drained", qa.size() + qb.size() + qa2.size() + qb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
